// File: rtl/fibo_pkg.sv
// fibo_pkg: shared state encodings, ALU opcodes, register indices and control word for the Fibonacci controller.
package fibo_pkg;
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_CNT = 4'd1,
        INIT0    = 4'd2,
        INIT1    = 4'd3,
        CHECK    = 4'd4,
        COPY     = 4'd5,
        ADD      = 4'd6,
        MOVE     = 4'd7,
        DEC      = 4'd8,
        DONE     = 4'd9
    } state_t;
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_ONE   = 3'b001;
    localparam logic [2:0] OP_DEC   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;
    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;
    typedef struct packed {
        logic [1:0] wrt_addr;
        logic       wrt_en;
        logic       load_data;
        logic [1:0] rd_addr1;
        logic [1:0] rd_addr2;
        logic [2:0] alu_opcode;
    } ctrl_t;
endpackage

// File: rtl/fibo_ctrl_out_dec.sv
// fibo_ctrl_out_dec: maps the controller state to the datapath control word and status flags.
module fibo_ctrl_out_dec
    import fibo_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl,
    output logic       busy,
    output logic       done
);
    // Unlisted encodings fall through to the idle word so illegal states look like reset.
    always_comb begin
        ctrl = '{R0, 1'b0, 1'b0, R0, R0, OP_PASSB};
        case (state)
            LOAD_CNT: ctrl = '{R3, 1'b1, 1'b1, R0, R0, OP_NONE};
            INIT0:    ctrl = '{R0, 1'b1, 1'b0, R0, R0, OP_ONE};
            INIT1:    ctrl = '{R1, 1'b1, 1'b0, R0, R0, OP_ONE};
            CHECK:    ctrl = '{R0, 1'b0, 1'b0, R3, R3, OP_PASSB};
            COPY:     ctrl = '{R2, 1'b1, 1'b0, R0, R0, OP_PASSB};
            ADD:      ctrl = '{R0, 1'b1, 1'b0, R0, R1, OP_ADD};
            MOVE:     ctrl = '{R1, 1'b1, 1'b0, R1, R2, OP_PASSB};
            DEC:      ctrl = '{R3, 1'b1, 1'b0, R3, R0, OP_DEC};
            default:  ;
        endcase
    end
    assign busy = state inside {LOAD_CNT, INIT0, INIT1, CHECK, COPY, ADD, MOVE, DEC};
    assign done = state == DONE;
endmodule

// File: rtl/fibo_controller.sv
// fibo_controller: Moore FSM sequencing a register-file datapath through a Fibonacci run.
// Optional FIBO_CTRL_ITER_CNT_EN adds a 4-bit loop iteration counter output.
module fibo_controller
    import fibo_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       zero_flag,
    output logic [1:0] wrt_addr,
    output logic       wrt_en,
    output logic       load_data,
    output logic [1:0] rd_addr1,
    output logic [1:0] rd_addr2,
    output logic [2:0] alu_opcode,
    output logic       busy,
`ifdef FIBO_CTRL_ITER_CNT_EN
    output logic [3:0] iter_cnt,
`endif
    output logic       done
);
    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         cur;
    state_t             nxt;
    ctrl_t              ctrl;
    // Any set bit above the enum width is illegal; 4'hF is outside the enum too.
    assign cur = ((state_q >> 4) != '0) ? 4'hF : state_q[3:0];
    always_comb begin
        nxt = IDLE;
        case (cur)
            IDLE:     nxt = start ? LOAD_CNT : IDLE;
            LOAD_CNT: nxt = INIT0;
            INIT0:    nxt = INIT1;
            INIT1:    nxt = CHECK;
            CHECK:    nxt = zero_flag ? DONE : COPY;
            COPY:     nxt = ADD;
            ADD:      nxt = MOVE;
            MOVE:     nxt = DEC;
            DEC:      nxt = zero_flag ? DONE : COPY;
            DONE:     nxt = start ? LOAD_CNT : DONE;
            default:  nxt = IDLE;
        endcase
    end
    assign state_d = STATE_W'(nxt);
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= STATE_W'(IDLE);
        else     state_q <= state_d;
    end
    fibo_ctrl_out_dec u_dec (
        .state(cur),
        .ctrl (ctrl),
        .busy (busy),
        .done (done)
    );
    assign {wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode} = ctrl;
`ifdef FIBO_CTRL_ITER_CNT_EN
    logic [3:0] iter_q, iter_d;
    assign iter_d = (cur == LOAD_CNT) ? 4'd0 : (cur == DEC) ? iter_q + 4'd1 : iter_q;
    always_ff @(posedge Clk) begin
        if (Rst) iter_q <= 4'd0;
        else     iter_q <= iter_d;
    end
    assign iter_cnt = iter_q;
`endif
endmodule

// File: tb/tb_fibo_controller.sv
// tb_fibo_controller: directed bench driving fibo_controller against a small register-file/ALU model.
module tb_fibo_controller;
    import fibo_pkg::*;
    logic       Clk = 1'b0;
    logic       Rst, start, zero_flag;
    logic [1:0] wrt_addr, rd_addr1, rd_addr2;
    logic       wrt_en, load_data, busy, done;
    logic [2:0] alu_opcode;
    logic [3:0] cnt;
    logic [3:0] rf [4];
    logic [3:0] a, b, alu;
`ifdef FIBO_CTRL_ITER_CNT_EN
    logic [3:0] iter_cnt;
`endif
    int checks = 0;
    int errors = 0;
    int copy_n = 0, dec_n = 0, zero_at = 0;
    always #5 Clk = ~Clk;
    fibo_controller dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .zero_flag (zero_flag),
        .wrt_addr  (wrt_addr),
        .wrt_en    (wrt_en),
        .load_data (load_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .alu_opcode(alu_opcode),
        .busy      (busy),
`ifdef FIBO_CTRL_ITER_CNT_EN
        .iter_cnt  (iter_cnt),
`endif
        .done      (done)
    );
    always_comb begin
        a = rf[rd_addr1];
        b = rf[rd_addr2];
        alu = alu_opcode == OP_ONE ? 4'd1 : alu_opcode == OP_DEC ? a - 4'd1 :
              alu_opcode == OP_ADD ? a + b : alu_opcode == OP_PASSB ? b : 4'd0;
    end
    assign zero_flag = alu == 4'd0;
    always @(posedge Clk) if (wrt_en) rf[wrt_addr] <= load_data ? cnt : alu;
    always @(negedge Clk) begin
        if (busy && wrt_en && wrt_addr == R2) copy_n++;
        if (busy && wrt_en && wrt_addr == R3 && !load_data) begin
            dec_n++;
            if (zero_flag) zero_at = dec_n;
        end
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic run(input logic [3:0] n, input logic hold, output int cyc);
        cnt = n;
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (done) break;
        end
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_wen"}, wrt_en, 0);
        check({tag, "_load"}, load_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_waddr"}, wrt_addr, 0);
        check({tag, "_rd1"}, rd_addr1, 0);
        check({tag, "_rd2"}, rd_addr2, 0);
        check({tag, "_op"}, alu_opcode, 3'b111);
    endtask
    initial begin
        int cyc, db, cb, adds;
        Rst = 1'b1;
        start = 1'b0;
        cnt = 4'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_idle("rst");
        Rst = 1'b0;
        db = dec_n;
        run(4'd5, 1'b0, cyc);
        check("c5_cyc", cyc, 25);
        check("c5_out", alu, 13);
        check("c5_decs", dec_n - db, 5);
        check("c5_zero_dec", zero_at - db, 5);
        @(negedge Clk);
        check("c5_hold_done", done, 1);
        check("c5_hold_busy", busy, 0);
        db = dec_n;
        cb = copy_n;
        run(4'd0, 1'b0, cyc);
        check("c0_cyc", cyc, 5);
        check("c0_out", alu, 1);
        check("c0_copies", copy_n - cb, 0);
        check("c0_decs", dec_n - db, 0);
        run(4'd15, 1'b0, cyc);
        check("c15_cyc", cyc, 65);
        check("c15_out", alu, 13);
`ifdef FIBO_CTRL_ITER_CNT_EN
        check("c15_iter", iter_cnt, 15);
`endif
        cnt = 4'd5;
        @(negedge Clk);
        start = 1'b1;
        adds = 0;
        for (int i = 0; i < 50 && adds < 2; i++) begin
            @(negedge Clk);
            start = 1'b0;
            if (wrt_en && wrt_addr == R0 && alu_opcode == OP_ADD) adds++;
        end
        check("mid_adds", adds, 2);
        Rst = 1'b1;
        @(negedge Clk);
        check("mid_busy", busy, 0);
        check("mid_wen", wrt_en, 0);
        check("mid_done", done, 0);
        Rst = 1'b0;
        run(4'd3, 1'b0, cyc);
        check("c3_cyc", cyc, 17);
        check("c3_out", alu, 5);
        run(4'd2, 1'b1, cyc);
        check("held_cyc", cyc, 13);
        check("held_out", alu, 3);
        @(negedge Clk);
        check("held_restart_done", done, 0);
        check("held_restart_load", load_data, 1);
        check("held_restart_busy", busy, 1);
        start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clk);
            cyc++;
        end
        check("held_second_cyc", cyc, 13);
        check("held_second_out", alu, 3);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        force dut.state_q = 4'hF;
        #1;
        check("bad_busy_forced", busy, 0);
        check("bad_op_forced", alu_opcode, 3'b111);
        #2;
        release dut.state_q;
        @(posedge Clk);
        @(negedge Clk);
        check_idle("bad");
        @(negedge Clk);
        check("bad_stay_busy", busy, 0);
        check("bad_stay_done", done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
